// File: rtl/button_debounce_pkg.sv
// Shared types and helpers for the button debouncer.
package button_debounce_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } dbnc_state_t;

  // Width needed for a counter that must reach max_count without wrapping.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// One debounced button channel: 2-FF synchroniser, STABLE/CHECK FSM with
// terminal-count acceptance, press/release strobes and, when
// BUTTON_DEBOUNCE_LONG_PRESS_EN is defined, a long-press hold counter.
module button_debounce_ch
  import button_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter bit ACTIVE_LOW        = 1'b1,
  parameter int LONG_PRESS_CYCLES = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_out,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int                 CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic               IDLE    = ACTIVE_LOW;
  localparam logic               PRESSED = ~ACTIVE_LOW;

  logic              s1;
  logic              s2;
  dbnc_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              accept_press;
  logic              accept_release;

  // Synchronise the raw pin; both stages reset to idle so no edge is seen after reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= IDLE;
      s2 <= IDLE;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // The mismatch has persisted long enough: the new level is accepted this cycle.
  assign accept         = (state == CHECK) && (s2 != btn_out) && (cnt == CNT_MAX);
  assign accept_press   = accept && (s2 == PRESSED);
  assign accept_release = accept && (s2 != PRESSED);

  // Debounce FSM: count consecutive mismatch cycles, accept at terminal count, reject glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= STABLE;
      cnt           <= '0;
      btn_out       <= IDLE;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= accept_press;
      release_pulse <= accept_release;
      case (state)
        STABLE: begin
          if (s2 != btn_out) begin
            state <= CHECK;
            cnt   <= CNT_W'(1);
          end
        end
        CHECK: begin
          if (s2 == btn_out) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state   <= STABLE;
            cnt     <= '0;
            btn_out <= s2;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int                HOLD_W   = cnt_width(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);

  logic [HOLD_W-1:0] hold_cnt;
  logic              armed;

  // Time an accepted press; fire one long-press strobe per press, cancel on release.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt   <= '0;
      armed      <= 1'b0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (accept_press) begin
        hold_cnt <= HOLD_W'(1);
        armed    <= 1'b1;
      end else if (accept_release) begin
        hold_cnt <= '0;
        armed    <= 1'b0;
      end else if (armed) begin
        if (hold_cnt == HOLD_MAX) begin
          long_press <= 1'b1;
          armed      <= 1'b0;
        end else begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
        end
      end
    end
  end
`else
  // Long-press timing is not built; the parameter is kept so both builds share one interface.
  localparam int UNUSED_LONG_PRESS = LONG_PRESS_CYCLES;
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// Multi-channel button synchroniser/debouncer. btn_out keeps the raw pin
// polarity so it can feed a PIO directly; press/release strobes are one cycle.
// Optional long-press strobe: define BUTTON_DEBOUNCE_LONG_PRESS_EN.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int WIDTH             = 1,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter bit ACTIVE_LOW        = 1'b1,
  parameter int LONG_PRESS_CYCLES = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] long_press
);

  // Independent channels, one debouncer per button.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .ACTIVE_LOW       (ACTIVE_LOW),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .btn_raw      (btn_raw[i]),
      .btn_out      (btn_out[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_press   (long_press[i])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce (WIDTH=2, DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=20, active-low). Directed scenarios followed by random
// per-channel bouncing, all compared every cycle against a reference model.
module tb_button_debounce;

  localparam int W = 2;
  localparam int D = 4;
  localparam int L = 20;

  logic         clk;
  logic         reset;
  logic [W-1:0] btn_raw;
  logic [W-1:0] btn_out;
  logic [W-1:0] press_pulse;
  logic [W-1:0] release_pulse;
  logic [W-1:0] long_press;

  int n_total;
  int n_pass;

  // Reference model: raw samples delayed two edges, a mismatch run length,
  // and an age counter for the current accepted press.
  logic         m_d1  [W];
  logic         m_d2  [W];
  logic         m_out [W];
  int           m_run [W];
  bit           m_armed [W];
  int           m_age [W];
  logic [W-1:0] e_out;
  logic [W-1:0] e_press;
  logic [W-1:0] e_rel;
  logic [W-1:0] e_long;

  button_debounce #(
    .WIDTH            (W),
    .DEBOUNCE_CYCLES  (D),
    .ACTIVE_LOW       (1'b1),
    .LONG_PRESS_CYCLES(L)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btn_raw),
    .btn_out      (btn_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance the model by one clock edge with the inputs sampled at that edge.
  task automatic model_edge(input logic [W-1:0] raw, input logic rst);
    for (int c = 0; c < W; c++) begin
      e_press[c] = 1'b0;
      e_rel[c]   = 1'b0;
      e_long[c]  = 1'b0;
      if (rst) begin
        m_d1[c] = 1'b1; m_d2[c] = 1'b1; m_out[c] = 1'b1;
        m_run[c] = 0; m_armed[c] = 1'b0; m_age[c] = 0;
      end else begin
        // A level is accepted once it has differed from the output for D+1 edges in a row.
        if (m_d2[c] != m_out[c]) begin
          m_run[c]++;
          if (m_run[c] == D + 1) begin
            m_out[c] = m_d2[c];
            m_run[c] = 0;
            if (m_out[c] == 1'b0) begin
              e_press[c] = 1'b1; m_armed[c] = 1'b1; m_age[c] = 0;
            end else begin
              e_rel[c] = 1'b1; m_armed[c] = 1'b0;
            end
          end
        end else begin
          m_run[c] = 0;
        end
        if (m_armed[c] && !e_press[c]) begin
          m_age[c]++;
          if (m_age[c] == L) begin
            e_long[c]  = 1'b1;
            m_armed[c] = 1'b0;
          end
        end
        m_d2[c] = m_d1[c];
        m_d1[c] = raw[c];
      end
      e_out[c] = m_out[c];
    end
`ifndef BUTTON_DEBOUNCE_LONG_PRESS_EN
    e_long = '0;
`endif
  endtask

  // Apply inputs, take one clock edge, then compare all outputs 1 time unit later.
  task automatic step(input logic [W-1:0] raw, input logic rst);
    btn_raw = raw;
    reset   = rst;
    @(posedge clk);
    model_edge(raw, rst);
    #1;
    check("btn_out", 32'(btn_out), 32'(e_out));
    check("press_pulse", 32'(press_pulse), 32'(e_press));
    check("release_pulse", 32'(release_pulse), 32'(e_rel));
    check("long_press", 32'(long_press), 32'(e_long));
  endtask

  initial begin
    int           lp_count;
    int           lp_edge;
    int           pr_edge;
    int           remain [W];
    logic [W-1:0] lvl;

    n_total = 0;
    n_pass  = 0;
    btn_raw = 2'b11;
    reset   = 1'b1;
    for (int c = 0; c < W; c++) begin
      m_d1[c] = 1'b1; m_d2[c] = 1'b1; m_out[c] = 1'b1;
      m_run[c] = 0; m_armed[c] = 1'b0; m_age[c] = 0;
    end

    // Reset state, held and after release.
    for (int k = 0; k < 3; k++) step(2'b11, 1'b1);
    check("reset_btn_out", 32'(btn_out), 32'h3);
    for (int k = 0; k < 4; k++) step(2'b11, 1'b0);
    check("post_reset_strobes", 32'({press_pulse, release_pulse, long_press}), 32'h0);

    // Clean press on channel 0: accepted at edge 6 only.
    for (int k = 0; k < 10; k++) begin
      step(2'b10, 1'b0);
      check("press_edge6", 32'(press_pulse[0]), 32'(k == 6));
      check("press_out0", 32'(btn_out[0]), 32'(k < 6));
      check("press_ch1_idle", 32'(btn_out[1]), 32'h1);
    end

    // Release: strobe 6 edges after the first high sample.
    for (int k = 0; k < 10; k++) begin
      step(2'b11, 1'b0);
      check("release_edge6", 32'(release_pulse[0]), 32'(k == 6));
    end
    check("release_out", 32'(btn_out), 32'h3);

    // Bounce: 3-cycle low is rejected.
    for (int k = 0; k < 11; k++) begin
      step((k < 3) ? 2'b10 : 2'b11, 1'b0);
      check("bounce_out", 32'(btn_out), 32'h3);
      check("bounce_press", 32'(press_pulse), 32'h0);
    end

    // A 5-cycle low is accepted; its release follows.
    for (int k = 0; k < 12; k++) begin
      step((k < 5) ? 2'b10 : 2'b11, 1'b0);
      check("short_press", 32'(press_pulse[0]), 32'(k == 6));
      check("short_release", 32'(release_pulse[0]), 32'(k == 11));
    end
    for (int k = 0; k < 4; k++) step(2'b11, 1'b0);

    // Reset during CHECK abandons the debounce; a fresh press takes the full latency.
    for (int k = 0; k < 4; k++) step(2'b10, 1'b0);
    step(2'b10, 1'b1);
    check("midreset_out", 32'(btn_out[0]), 32'h1);
    check("midreset_strobe", 32'(press_pulse[0] | release_pulse[0]), 32'h0);
    for (int k = 0; k < 10; k++) begin
      step(2'b10, 1'b0);
      check("after_reset_press", 32'(press_pulse[0]), 32'(k == 6));
    end
    for (int k = 0; k < 10; k++) step(2'b11, 1'b0);

    // Long hold on channel 1.
    lp_count = 0;
    lp_edge  = -1;
    pr_edge  = -1;
    for (int k = 0; k < 40; k++) begin
      step(2'b01, 1'b0);
      if (press_pulse[1]) pr_edge = k;
      if (long_press[1]) begin
        lp_count++;
        lp_edge = k;
      end
    end
    check("long_press_edge", 32'(pr_edge), 32'd6);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    check("long_press_count", 32'(lp_count), 32'd1);
    check("long_press_time", 32'(lp_edge), 32'd26);
`else
    check("long_press_count", 32'(lp_count), 32'd0);
`endif
    for (int k = 0; k < 10; k++) step(2'b11, 1'b0);

    // Random bouncing on both channels, with occasional resets.
    lvl = 2'b11;
    for (int c = 0; c < W; c++) remain[c] = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < W; c++) begin
        remain[c]--;
        if (remain[c] <= 0) begin
          lvl[c]    = ~lvl[c];
          remain[c] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(10, 30))
                                                   : int'($urandom_range(1, 8));
        end
      end
      step(lvl, ($urandom_range(0, 299) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
